// File: rtl/secp256k1_inv_mod_serial.sv
// Serial Fermat inverse a^(p-2) mod p for secp256k1, driving an external serial
// modular multiplier through a single-outstanding start/done handshake.
module secp256k1_inv_mod_serial #(
  parameter logic [255:0] EXP   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2D,
  parameter logic [255:0] PRIME = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [255:0] a_i,
  output logic [255:0] result_o,
  output logic         done_o,
  output logic         busy_o,
  output logic         zero_err_o,
  output logic         mul_start_o,
  output logic [255:0] mul_a_o,
  output logic [255:0] mul_b_o,
  input  logic [255:0] mul_result_i,
  input  logic         mul_done_i
);

  typedef enum logic [2:0] {
    IDLE, CHECK, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, NEXT, FINISH
  } state_t;

  state_t       state_q;
  logic [255:0] base_q, acc_q, result_q, mul_a_q, mul_b_q;
  logic [7:0]   idx_q;
  logic         done_q, busy_q, zero_err_q, mul_start_q;
  logic [256:0] diff_d;
  logic [255:0] base_d;

  // Single conditional subtract: inputs are assumed below 2^256, so one pass suffices.
  assign diff_d = {1'b0, a_i} - {1'b0, PRIME};
  assign base_d = diff_d[256] ? a_i : diff_d[255:0];

  // Requests are registered on entry to *_REQ, so mul_start is high exactly during REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      zero_err_q  <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          base_q     <= base_d;
          zero_err_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= CHECK;
        end
        CHECK: if (base_q == '0) begin
          result_q   <= '0;
          zero_err_q <= 1'b1;
          state_q    <= FINISH;
        end else begin
          acc_q       <= base_q;
          idx_q       <= 8'd254;
          mul_a_q     <= base_q;
          mul_b_q     <= base_q;
          mul_start_q <= 1'b1;
          state_q     <= SQR_REQ;
        end
        SQR_REQ: state_q <= SQR_WAIT;
        SQR_WAIT: if (mul_done_i) begin
          acc_q <= mul_result_i;
          if (EXP[idx_q]) begin
            mul_a_q     <= mul_result_i;
            mul_b_q     <= base_q;
            mul_start_q <= 1'b1;
            state_q     <= MUL_REQ;
          end else begin
            state_q <= NEXT;
          end
        end
        MUL_REQ: state_q <= MUL_WAIT;
        MUL_WAIT: if (mul_done_i) begin
          acc_q   <= mul_result_i;
          state_q <= NEXT;
        end
        NEXT: if (idx_q == 8'd0) begin
          result_q <= acc_q;
          state_q  <= FINISH;
        end else begin
          idx_q       <= idx_q - 8'd1;
          mul_a_q     <= acc_q;
          mul_b_q     <= acc_q;
          mul_start_q <= 1'b1;
          state_q     <= SQR_REQ;
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_o    = result_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign zero_err_o  = zero_err_q;
  assign mul_start_o = mul_start_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;

endmodule
